// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_rr
//  Description : N-port memory arbiter in front of a single valid/ready
//                memory port. Grants are issued combinationally in IDLE
//                (round-robin or fixed highest-index priority), held until
//                the memory signals completion, and the response is steered
//                back to the owning port only.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr #(
  parameter int NPORTS  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS-1:0]          req_valid,
  input  logic [NPORTS-1:0]          req_instr,
  input  logic [NPORTS*ADDR_W-1:0]   req_addr,
  input  logic [NPORTS*DATA_W-1:0]   req_wdata,
  input  logic [NPORTS*DATA_W/8-1:0] req_wstrb,
  output logic [NPORTS*DATA_W-1:0]   rsp_rdata,
  output logic [NPORTS-1:0]          rsp_ready,
  output logic                       memory_valid,
  output logic                       memory_instr,
  output logic [ADDR_W-1:0]          memory_addr,
  output logic [DATA_W-1:0]          memory_wdata,
  output logic [DATA_W/8-1:0]        memory_wstrb,
  input  logic [DATA_W-1:0]          memory_rdata,
  input  logic                       memory_ready
);

  localparam int c_strb_w = DATA_W / 8;
  localparam int c_own_w  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam bit c_rr     = (RR_MODE != 0);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_own_w-1:0]   r_owner;
  logic [c_own_w-1:0]   w_owner_nxt;
  logic [c_own_w-1:0]   r_ptr;
  logic [c_own_w-1:0]   w_ptr_nxt;

  logic                 w_grant_any;
  logic [c_own_w-1:0]   w_grant_idx;
  logic                 w_active;
  logic [c_own_w-1:0]   w_sel;
  logic                 w_done;

  // Port index arithmetic modulo NPORTS (NPORTS need not be a power of two)
  function automatic logic [c_own_w-1:0] wrap_add(input logic [c_own_w-1:0] base,
                                                  input int                 inc);
    int sum;
    sum = int'(base) + inc;
    if (sum >= NPORTS) begin
      sum = sum - NPORTS;
    end
    return c_own_w'(sum);
  endfunction

  generate
    if (c_rr) begin : g_rr_sel
      // Round-robin: first valid port searched upward from the pointer
      always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NPORTS; k++) begin
          if (!w_grant_any && req_valid[wrap_add(r_ptr, k)]) begin
            w_grant_any = 1'b1;
            w_grant_idx = wrap_add(r_ptr, k);
          end
        end
      end
    end else begin : g_fixed_sel
      // Fixed priority: the highest-index valid port wins (later hits overwrite)
      always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
          if (req_valid[i]) begin
            w_grant_any = 1'b1;
            w_grant_idx = c_own_w'(i);
          end
        end
      end
    end
  endgenerate

  // Pick the port currently driving the memory: locked owner in BUSY, fresh grant in IDLE
  always_comb begin
    w_sel    = (r_state == S_BUSY) ? r_owner : w_grant_idx;
    w_active = (r_state == S_BUSY) || w_grant_any;
    w_done   = rst && w_active && memory_ready;
  end

  // Memory-side request mux; everything is zero in reset or when nobody is selected
  always_comb begin
    memory_valid = 1'b0;
    memory_instr = 1'b0;
    memory_addr  = '0;
    memory_wdata = '0;
    memory_wstrb = '0;
    if (rst && w_active) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (w_sel == c_own_w'(i)) begin
          // In BUSY the owner's live valid is forwarded, even if it drops early
          memory_valid = req_valid[i];
          memory_instr = req_instr[i];
          memory_addr  = req_addr[i*ADDR_W +: ADDR_W];
          memory_wdata = req_wdata[i*DATA_W +: DATA_W];
          memory_wstrb = req_wstrb[i*c_strb_w +: c_strb_w];
        end
      end
    end
  end

  // Response steering: only the completing port sees ready and read data
  always_comb begin
    rsp_ready = '0;
    rsp_rdata = '0;
    if (w_done) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (w_sel == c_own_w'(i)) begin
          rsp_ready[i]                   = 1'b1;
          rsp_rdata[i*DATA_W +: DATA_W]  = memory_rdata;
        end
      end
    end
  end

  // Next-state logic for the grant lock and the round-robin pointer
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        // A single-cycle transfer completes here and never enters BUSY
        if (w_grant_any && !memory_ready) begin
          w_state_nxt = S_BUSY;
          w_owner_nxt = w_grant_idx;
        end
      end
      S_BUSY: begin
        if (memory_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Just-served port drops to lowest priority for the next arbitration
    if (c_rr && w_done) begin
      w_ptr_nxt = wrap_add(w_sel, 1);
    end
  end

  // State, owner and pointer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter_rr
//  Description : Directed self-checking bench for mem_arbiter_rr. One 4-port
//                round-robin instance and one 2-port fixed-priority instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_rr;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // 4-port round-robin instance
  logic [3:0]   v4, i4, rr4;
  logic [127:0] a4, wd4, rd4;
  logic [15:0]  ws4;
  logic         m4_valid, m4_instr, m4_ready;
  logic [31:0]  m4_addr, m4_wdata, m4_rdata;
  logic [3:0]   m4_wstrb;

  // 2-port fixed-priority instance
  logic [1:0]   v2, i2, rr2;
  logic [63:0]  a2, wd2, rd2;
  logic [7:0]   ws2;
  logic         m2_valid, m2_instr, m2_ready;
  logic [31:0]  m2_addr, m2_wdata, m2_rdata;
  logic [3:0]   m2_wstrb;

  mem_arbiter_rr #(.NPORTS(4), .ADDR_W(32), .DATA_W(32), .RR_MODE(1)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(v4), .req_instr(i4), .req_addr(a4), .req_wdata(wd4), .req_wstrb(ws4),
    .rsp_rdata(rd4), .rsp_ready(rr4),
    .memory_valid(m4_valid), .memory_instr(m4_instr), .memory_addr(m4_addr),
    .memory_wdata(m4_wdata), .memory_wstrb(m4_wstrb),
    .memory_rdata(m4_rdata), .memory_ready(m4_ready)
  );

  mem_arbiter_rr #(.NPORTS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(v2), .req_instr(i2), .req_addr(a2), .req_wdata(wd2), .req_wstrb(ws2),
    .rsp_rdata(rd2), .rsp_ready(rr2),
    .memory_valid(m2_valid), .memory_instr(m2_instr), .memory_addr(m2_addr),
    .memory_wdata(m2_wdata), .memory_wstrb(m2_wstrb),
    .memory_rdata(m2_rdata), .memory_ready(m2_ready)
  );

  task automatic set4(input int p, input logic v, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] ws, input logic ins);
    v4[p]          = v;
    i4[p]          = ins;
    a4[p*32 +: 32] = a;
    wd4[p*32 +: 32] = wd;
    ws4[p*4 +: 4]  = ws;
  endtask

  task automatic clear_all();
    v4 = '0; i4 = '0; a4 = '0; wd4 = '0; ws4 = '0; m4_ready = 1'b0; m4_rdata = '0;
    v2 = '0; i2 = '0; a2 = '0; wd2 = '0; ws2 = '0; m2_ready = 1'b0; m2_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_all();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_v;
    clear_all();
    rst = 1'b0;
    for (int p = 0; p < 4; p++) set4(p, 1'b1, 32'h1000 + p, 32'h0, 4'h0, 1'b0);
    v2 = 2'b11; m4_ready = 1'b1; m2_ready = 1'b1; m4_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_cmp++; if (m4_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mvalid4 c%0d: got %b want 0", c, m4_valid); end
      n_cmp++; if (rr4 !== 4'b0) begin n_bad++; $display("FAIL reset_rready4 c%0d: got %b want 0000", c, rr4); end
      n_cmp++; if (rd4 !== 128'b0) begin n_bad++; $display("FAIL reset_rdata4 c%0d: got %h want 0", c, rd4); end
      n_cmp++; if (m4_addr !== 32'h0) begin n_bad++; $display("FAIL reset_maddr4 c%0d: got %h want 0", c, m4_addr); end
      n_cmp++; if (m2_valid !== 1'b0 || rr2 !== 2'b0) begin n_bad++; $display("FAIL reset_dut2 c%0d: got v=%b r=%b want 0", c, m2_valid, rr2); end
    end
    @(negedge clk); rst = 1'b1; m4_ready = 1'b0; m2_ready = 1'b0; v2 = 2'b0; #1;
    n_cmp++; if (m4_valid !== 1'b1) begin n_bad++; $display("FAIL reset_first_valid: got %b want 1", m4_valid); end
    n_cmp++; if (m4_addr !== 32'h1000) begin n_bad++; $display("FAIL reset_first_grant: got %h want 00001000", m4_addr); end
    @(negedge clk); m4_ready = 1'b1; m4_rdata = 32'hA5A5_0000; #1;
    exp_v = 4'b0001;
    n_cmp++; if (rr4 !== exp_v) begin n_bad++; $display("FAIL reset_first_rsp: got %b want %b", rr4, exp_v); end
    n_cmp++; if (rd4 !== {96'b0, 32'hA5A5_0000}) begin n_bad++; $display("FAIL reset_first_rdata: got %h want A5A50000 in slice0", rd4); end
    @(negedge clk); clear_all();
  endtask

  task automatic test_wait_states();
    do_reset();
    @(negedge clk); set4(2, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0); m4_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (m4_addr !== 32'h100 || m4_valid !== 1'b1) begin n_bad++; $display("FAIL wait_addr c%0d: got %h/%b want 00000100/1", c, m4_addr, m4_valid); end
      n_cmp++; if (rr4 !== 4'b0) begin n_bad++; $display("FAIL wait_noready c%0d: got %b want 0000", c, rr4); end
      @(negedge clk);
    end
    m4_ready = 1'b1; m4_rdata = 32'hDEAD_BEEF; #1;
    n_cmp++; if (m4_addr !== 32'h100) begin n_bad++; $display("FAIL wait_addr_last: got %h want 00000100", m4_addr); end
    n_cmp++; if (rr4 !== 4'b0100) begin n_bad++; $display("FAIL wait_rsp: got %b want 0100", rr4); end
    n_cmp++; if (rd4 !== {32'h0, 32'hDEAD_BEEF, 64'h0}) begin n_bad++; $display("FAIL wait_rdata: got %h want DEADBEEF in slice2 only", rd4); end
    // Pointer now 3: with ports 0 and 3 pending, port 3 must win
    @(negedge clk); clear_all();
    set4(0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
    set4(3, 1'b1, 32'h300, 32'h0, 4'h0, 1'b0); #1;
    n_cmp++; if (m4_addr !== 32'h300) begin n_bad++; $display("FAIL wait_ptr3: got %h want 00000300", m4_addr); end
    @(negedge clk); m4_ready = 1'b1; #1;
    n_cmp++; if (rr4 !== 4'b1000) begin n_bad++; $display("FAIL wait_ptr3_rsp: got %b want 1000", rr4); end
    @(negedge clk); clear_all();
  endtask

  task automatic test_rr_fairness();
    int cnt [4];
    logic [3:0] exp_v;
    int exp_p;
    for (int p = 0; p < 4; p++) cnt[p] = 0;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      exp_p = t % 4;
      @(negedge clk);
      for (int p = 0; p < 4; p++) set4(p, 1'b1, 32'h1000 + p, 32'h0, 4'h0, 1'b0);
      m4_ready = 1'b0; #1;
      n_cmp++; if (m4_addr !== 32'h1000 + exp_p) begin n_bad++; $display("FAIL rr_grant t%0d: got %h want %h", t, m4_addr, 32'h1000 + exp_p); end
      @(negedge clk); m4_ready = 1'b1; m4_rdata = 32'hC000 + t; #1;
      exp_v = 4'b0001 << exp_p;
      n_cmp++; if (rr4 !== exp_v) begin n_bad++; $display("FAIL rr_rsp t%0d: got %b want %b", t, rr4, exp_v); end
      n_cmp++; if (rd4[exp_p*32 +: 32] !== 32'hC000 + t) begin n_bad++; $display("FAIL rr_rdata t%0d: got %h want %h", t, rd4[exp_p*32 +: 32], 32'hC000 + t); end
      if (t < 4) for (int p = 0; p < 4; p++) cnt[p] += int'(rr4[p]);
    end
    for (int p = 0; p < 4; p++) begin
      n_cmp++; if (cnt[p] !== 1) begin n_bad++; $display("FAIL rr_count p%0d: got %0d want 1", p, cnt[p]); end
    end
    @(negedge clk); clear_all();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    @(negedge clk);
    v2 = 2'b11; i2 = 2'b01; a2 = {32'h0000_00B0, 32'h0000_00A0}; m2_ready = 1'b0; #1;
    n_cmp++; if (m2_addr !== 32'hB0 || m2_instr !== 1'b0) begin n_bad++; $display("FAIL fix_first: got %h/%b want 000000B0/0", m2_addr, m2_instr); end
    n_cmp++; if (m2_wstrb !== 4'h0 || m2_wdata !== 32'h0) begin n_bad++; $display("FAIL fix_read: got %h/%h want 0/0", m2_wstrb, m2_wdata); end
    @(negedge clk); m2_ready = 1'b1; m2_rdata = 32'h1111_2222; #1;
    n_cmp++; if (rr2 !== 2'b10) begin n_bad++; $display("FAIL fix_rsp1: got %b want 10", rr2); end
    n_cmp++; if (rd2 !== {32'h1111_2222, 32'h0}) begin n_bad++; $display("FAIL fix_rdata1: got %h want 1111222200000000", rd2); end
    @(negedge clk); v2 = 2'b01; m2_ready = 1'b0; #1;
    n_cmp++; if (m2_addr !== 32'hA0 || m2_instr !== 1'b1) begin n_bad++; $display("FAIL fix_second: got %h/%b want 000000A0/1", m2_addr, m2_instr); end
    @(negedge clk); m2_ready = 1'b1; m2_rdata = 32'h3333_4444; #1;
    n_cmp++; if (rr2 !== 2'b01) begin n_bad++; $display("FAIL fix_rsp0: got %b want 01", rr2); end
    n_cmp++; if (rd2 !== {32'h0, 32'h3333_4444}) begin n_bad++; $display("FAIL fix_rdata0: got %h want 0000000033334444", rd2); end
    @(negedge clk); clear_all();
  endtask

  task automatic test_grant_lock();
    do_reset();
    @(negedge clk); set4(0, 1'b1, 32'h40, 32'h0, 4'h0, 1'b0); m4_ready = 1'b0; #1;
    n_cmp++; if (m4_addr !== 32'h40) begin n_bad++; $display("FAIL lock_start: got %h want 00000040", m4_addr); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); set4(3, 1'b1, 32'h3C0, 32'h1234_5678, 4'hF, 1'b0); #1;
      n_cmp++; if (m4_addr !== 32'h40 || m4_wstrb !== 4'h0) begin n_bad++; $display("FAIL lock_hold c%0d: got %h/%h want 00000040/0", c, m4_addr, m4_wstrb); end
      n_cmp++; if (rr4 !== 4'b0) begin n_bad++; $display("FAIL lock_noready c%0d: got %b want 0000", c, rr4); end
    end
    @(negedge clk); m4_ready = 1'b1; #1;
    n_cmp++; if (m4_addr !== 32'h40 || rr4 !== 4'b0001) begin n_bad++; $display("FAIL lock_done: got %h/%b want 00000040/0001", m4_addr, rr4); end
    @(negedge clk); set4(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0); m4_ready = 1'b0; #1;
    n_cmp++; if (m4_addr !== 32'h3C0 || m4_wstrb !== 4'hF) begin n_bad++; $display("FAIL lock_write: got %h/%h want 000003C0/F", m4_addr, m4_wstrb); end
    n_cmp++; if (m4_wdata !== 32'h1234_5678) begin n_bad++; $display("FAIL lock_wdata: got %h want 12345678", m4_wdata); end
    @(negedge clk); m4_ready = 1'b1; #1;
    n_cmp++; if (rr4 !== 4'b1000) begin n_bad++; $display("FAIL lock_wrsp: got %b want 1000", rr4); end
    @(negedge clk); clear_all();
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); set4(1, 1'b1, 32'h11, 32'h0, 4'h0, 1'b1);
      m4_ready = 1'b1; m4_rdata = 32'hB0 + c; #1;
      n_cmp++; if (rr4 !== 4'b0010) begin n_bad++; $display("FAIL zw_rsp c%0d: got %b want 0010", c, rr4); end
      n_cmp++; if (rd4[63:32] !== 32'hB0 + c) begin n_bad++; $display("FAIL zw_rdata c%0d: got %h want %h", c, rd4[63:32], 32'hB0 + c); end
      n_cmp++; if (m4_addr !== 32'h11 || m4_instr !== 1'b1) begin n_bad++; $display("FAIL zw_addr c%0d: got %h/%b want 00000011/1", c, m4_addr, m4_instr); end
    end
    @(negedge clk); clear_all(); m4_ready = 1'b1; m4_rdata = 32'hFEED; #1;
    n_cmp++; if (rr4 !== 4'b0 || rd4 !== 128'b0) begin n_bad++; $display("FAIL spur_rsp: got %b/%h want 0/0", rr4, rd4); end
    n_cmp++; if (m4_valid !== 1'b0 || m4_addr !== 32'h0) begin n_bad++; $display("FAIL spur_mem: got %b/%h want 0/0", m4_valid, m4_addr); end
    // Still IDLE with pointer 2: ports 0 and 3 pending, port 3 granted at once
    @(negedge clk); m4_ready = 1'b0;
    set4(0, 1'b1, 32'h30, 32'h0, 4'h0, 1'b0);
    set4(3, 1'b1, 32'h33, 32'h0, 4'h0, 1'b0); #1;
    n_cmp++; if (m4_addr !== 32'h33 || m4_valid !== 1'b1) begin n_bad++; $display("FAIL spur_idle: got %h/%b want 00000033/1", m4_addr, m4_valid); end
    @(negedge clk); m4_ready = 1'b1; #1;
    n_cmp++; if (rr4 !== 4'b1000) begin n_bad++; $display("FAIL spur_done: got %b want 1000", rr4); end
    @(negedge clk); clear_all();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); set4(2, 1'b1, 32'h22, 32'h0, 4'h0, 1'b0); m4_ready = 1'b0; #1;
    n_cmp++; if (m4_addr !== 32'h22) begin n_bad++; $display("FAIL mid_start: got %h want 00000022", m4_addr); end
    @(negedge clk); rst = 1'b0; m4_ready = 1'b1; #1;
    n_cmp++; if (m4_valid !== 1'b0 || rr4 !== 4'b0) begin n_bad++; $display("FAIL mid_forced: got %b/%b want 0/0000", m4_valid, rr4); end
    @(negedge clk); rst = 1'b1; m4_ready = 1'b0;
    set4(0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0);
    set4(1, 1'b1, 32'h21, 32'h0, 4'h0, 1'b0); #1;
    n_cmp++; if (m4_addr !== 32'h20) begin n_bad++; $display("FAIL mid_regrant: got %h want 00000020", m4_addr); end
    @(negedge clk); m4_ready = 1'b1; #1;
    n_cmp++; if (rr4 !== 4'b0001) begin n_bad++; $display("FAIL mid_rsp: got %b want 0001", rr4); end
    @(negedge clk); clear_all();
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_rr_fairness();
    test_fixed_priority();
    test_grant_lock();
    test_zero_wait();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- N-port memory arbiter between requesters (fetch unit, load/store unit, debug/DMA masters) and a single memory port using the valid/ready bus.
- Generalises the two-port instr/data arbiter to any port count, with selectable fixed-priority or round-robin arbitration.
- Locks the grant until the memory completes the transfer, and routes rdata/ready back to the owning port only.

Parameters:
- NPORTS, 2, number of requester ports (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the strobe width is DATA_W/8.
- RR_MODE, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (highest index wins).

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-low, on clock clk
- req_valid  in  NPORTS  per-port request valid
- req_instr  in  NPORTS  per-port instruction-fetch flag
- req_addr  in  NPORTS*ADDR_W  per-port address; port i occupies slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  NPORTS*DATA_W  per-port write data, sliced the same way
- req_wstrb  in  NPORTS*DATA_W/8  per-port write strobes; all-zero means read
- rsp_rdata  out  NPORTS*DATA_W  per-port read data
- rsp_ready  out  NPORTS  per-port completion strobe
- memory_valid  out  1  request valid to memory
- memory_instr  out  1  instruction flag to memory
- memory_addr  out  ADDR_W  address to memory
- memory_wdata  out  DATA_W  write data to memory
- memory_wstrb  out  DATA_W/8  write strobes to memory
- memory_rdata  in  DATA_W  read data from memory
- memory_ready  in  1  memory completion strobe

Behaviour:
- Requester protocol: a port holds valid, addr, wdata and wstrb stable from assertion until it sees its rsp_ready. It may issue a new request in the cycle after its rsp_ready.

State machine: IDLE / BUSY, plus registers owner (log2 NPORTS bits) and ptr (round-robin pointer).
- Reset (rst=0 at posedge): state=IDLE, owner=0, ptr=0.
- While rst=0, all memory_* outputs and all rsp_* outputs are forced to 0.

Grant selection in IDLE (combinational, zero added latency):
- RR_MODE=1: the first valid port searched from ptr upward, wrapping modulo NPORTS.
- RR_MODE=0: the highest-index valid port.
- The selected port's signals drive memory_* in the same cycle.
- No valid port: memory_valid=0 and all other memory_* outputs are 0.

IDLE transitions:
- Grant issued and memory_ready=0: go to BUSY; owner <= selected port.
- Grant issued and memory_ready=1 (single-cycle transfer): stay in IDLE; complete immediately to the selected port.

BUSY behaviour:
- memory_* are driven from port owner's live inputs.
- New requests from other ports are ignored; no preemption.
- memory_ready=1: complete; state <= IDLE.

Completion:
- rsp_ready[owner]=1 and rsp_rdata slice[owner]=memory_rdata for exactly that cycle.
- In RR mode, ptr <= (owner+1) mod NPORTS on completion; fixed mode never updates ptr.
- Non-owner ports always see rsp_ready=0 and rsp_rdata=0.

Back-to-back requests:
- The cycle after a completion, state is IDLE and arbitration runs again.
- In RR mode the just-served port has lowest priority, so no port waits more than NPORTS-1 transfers.

Boundary cases:
- memory_ready while IDLE with no valid request: ignored; no rsp_ready, no state change.
- Owner drops valid while BUSY (protocol violation): memory_valid follows the input low; the arbiter stays BUSY until memory_ready.
- Reset mid-transfer: the arbiter returns to IDLE at once. The memory side must be reset in the same cycle.
- NPORTS=2 with RR_MODE=0: port 1 (data) has priority over port 0 (fetch), matching the current two-port arbiter.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with all req_valid=1 -> memory_valid=0 and rsp_ready=0 throughout; after release, RR mode grants port 0 first.
2. Single port, wait states: port 2 reads addr 0x100 in NPORTS=4 RR mode; memory asserts ready after 3 cycles with rdata 0xDEADBEEF -> memory_addr=0x100 for all 4 cycles; rsp_ready[2] pulses once with rdata 0xDEADBEEF; ptr=3.
3. Round-robin fairness: all 4 ports continuously valid, memory ready every 2nd cycle -> grant order 0,1,2,3,0; each port gets exactly one rsp_ready per 4 transfers.
4. Fixed priority: RR_MODE=0, NPORTS=2, port 0 and port 1 valid simultaneously -> port 1 is served first; port 0 is granted in the IDLE cycle after port 1 completes.
5. Grant lock: port 0 is BUSY (ready delayed 5 cycles) when port 3 asserts valid with wstrb=0xF -> memory_addr stays on port 0 until its ready; port 3's write issues next; memory_wstrb=0xF.
6. Zero-wait plus spurious ready: memory_ready tied high with port 1 valid -> single-cycle completions on consecutive cycles. Pulse memory_ready with no valid requests -> no rsp_ready and the state stays IDLE.
